// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    VEND  = 2'd2
  } state_t;

  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE  = 2'd0;
  localparam err_t ERR_SLOT  = 2'd1;
  localparam err_t ERR_SOLD  = 2'd2;
  localparam err_t ERR_FUNDS = 2'd3;

endpackage

// File: rtl/vend_credit_acc.sv
// Credit accumulator.
// A coin is accepted only when the caller enables it and the new total stays
// at or below MAX_CREDIT. Otherwise it is bounced with a one-cycle reject.
// A clear (refund or completed vend) wins over any coin in the same cycle.
module vend_credit_acc #(
  parameter int CREDIT_W   = 10,
  parameter int COIN_W     = 7,
  parameter int MAX_CREDIT = 1000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_coin_valid,
  input  logic [COIN_W-1:0]   i_coin_value,
  input  logic                i_coin_en,
  input  logic                i_clear,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_coin_reject
);

  localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);

  logic [CREDIT_W-1:0] r_credit;
  logic                r_coin_reject;
  logic [CREDIT_W:0]   w_sum;
  logic                w_accept;

  // One spare bit so an overflowing sum is still compared correctly.
  assign w_sum    = {1'b0, r_credit} + (CREDIT_W+1)'(i_coin_value);
  assign w_accept = i_coin_valid && i_coin_en && (w_sum <= MAX_EXT);

  // Credit register and reject pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credit      <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      if (i_clear) begin
        r_credit <= '0;
      end else if (w_accept) begin
        r_credit <= w_sum[CREDIT_W-1:0];
      end
      r_coin_reject <= i_coin_valid && !w_accept;
    end
  end

  assign o_credit      = r_credit;
  assign o_coin_reject = r_coin_reject;

endmodule

// File: rtl/vend_controller_multi.sv
// Vending controller: coin credit, selection checking, dispense handshake
// and change/refund. Every output comes from a register.
// Optional macro VEND_TIMEOUT_EN adds an idle auto-refund timer.
module vend_controller_multi
  import vend_pkg::*;
#(
  parameter int NUM_SLOTS   = 16,
  parameter int SLOT_W      = $clog2(NUM_SLOTS),
  parameter int CREDIT_W    = 10,
  parameter int MAX_CREDIT  = 1000,
  parameter int COIN_W      = 7,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_coin_valid,
  input  logic [COIN_W-1:0]             i_coin_value,
  input  logic                          i_return_all,
  input  logic                          i_sel_valid,
  input  logic [SLOT_W-1:0]             i_sel_slot,
  input  logic [NUM_SLOTS*CREDIT_W-1:0] i_prices,
  input  logic [NUM_SLOTS-1:0]          i_in_stock,
  input  logic                          i_dispense_done,
  output logic [CREDIT_W-1:0]           o_credit,
  output logic                          o_coin_reject,
  output logic [CREDIT_W-1:0]           o_change,
  output logic                          o_change_valid,
  output logic                          o_sel_err,
  output logic [1:0]                    o_err_code,
  output logic                          o_dispense_go,
  output logic [SLOT_W-1:0]             o_dispense_slot,
  output logic                          o_busy,
  output logic                          o_timeout_refund
);

  state_t              r_state;
  logic [SLOT_W-1:0]   r_slot;
  logic [CREDIT_W-1:0] r_change;
  logic                r_change_valid;
  logic                r_sel_err;
  err_t                r_err_code;
  logic                r_dispense_go;
  logic [SLOT_W-1:0]   r_dispense_slot;
  logic                r_busy;
  logic                r_timeout_refund;

  logic [CREDIT_W-1:0] w_credit;
  logic [CREDIT_W-1:0] w_price;
  logic                w_stocked;
  logic                w_slot_bad;
  logic                w_timeout_fire;
  logic                w_refund;
  logic                w_coin_en;
  logic                w_clear;

  assign w_refund  = (r_state == IDLE) &&
                     ((i_return_all && (w_credit != '0)) || w_timeout_fire);
  // Coins only count in IDLE when nothing of higher priority is happening.
  assign w_coin_en = (r_state == IDLE) && !i_return_all && !i_sel_valid &&
                     !w_timeout_fire;
  assign w_clear   = w_refund || ((r_state == VEND) && i_dispense_done);

  vend_credit_acc #(
    .CREDIT_W   (CREDIT_W),
    .COIN_W     (COIN_W),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_credit (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_coin_valid  (i_coin_valid),
    .i_coin_value  (i_coin_value),
    .i_coin_en     (w_coin_en),
    .i_clear       (w_clear),
    .o_credit      (w_credit),
    .o_coin_reject (o_coin_reject)
  );

  // Look up price and stock of the latched slot; out-of-range slots read as 0.
  always_comb begin
    w_price   = '0;
    w_stocked = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (int'(r_slot) == i) begin
        w_price   = i_prices[i*CREDIT_W +: CREDIT_W];
        w_stocked = i_in_stock[i];
      end
    end
  end

  assign w_slot_bad = (int'(r_slot) >= NUM_SLOTS);

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_run;

  assign w_to_run       = (r_state == IDLE) && (w_credit != '0) &&
                          !i_coin_valid && !i_sel_valid && !i_return_all;
  // Fires on the TIMEOUT_CYC-th idle cycle; a coin in that cycle is bounced.
  assign w_timeout_fire = (r_state == IDLE) && (w_credit != '0) &&
                          (r_to_cnt == '0);

  // Idle down-counter, reloaded by any activity or by leaving IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= TO_LOAD;
    end else if (!w_to_run || w_timeout_fire) begin
      r_to_cnt <= TO_LOAD;
    end else begin
      r_to_cnt <= r_to_cnt - 1'b1;
    end
  end
`else
  // No timer in this build; TIMEOUT_CYC is only meaningful with the timer.
  assign w_timeout_fire = (TIMEOUT_CYC < 0);
`endif

  // Main FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= IDLE;
      r_slot           <= '0;
      r_change         <= '0;
      r_change_valid   <= 1'b0;
      r_sel_err        <= 1'b0;
      r_err_code       <= ERR_NONE;
      r_dispense_go    <= 1'b0;
      r_dispense_slot  <= '0;
      r_busy           <= 1'b0;
      r_timeout_refund <= 1'b0;
    end else begin
      r_change_valid   <= 1'b0;
      r_sel_err        <= 1'b0;
      r_timeout_refund <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_refund) begin
            r_change         <= w_credit;
            r_change_valid   <= 1'b1;
            r_timeout_refund <= w_timeout_fire;
          end else if (i_sel_valid && !i_return_all) begin
            r_slot  <= i_sel_slot;
            r_state <= CHECK;
            r_busy  <= 1'b1;
          end
        end
        CHECK: begin
          if (w_slot_bad || !w_stocked || (w_credit < w_price)) begin
            r_sel_err  <= 1'b1;
            r_err_code <= w_slot_bad ? ERR_SLOT :
                          (!w_stocked ? ERR_SOLD : ERR_FUNDS);
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end else begin
            r_dispense_go   <= 1'b1;
            r_dispense_slot <= r_slot;
            r_change        <= w_credit - w_price;
            r_state         <= VEND;
          end
        end
        VEND: begin
          if (i_dispense_done) begin
            r_dispense_go  <= 1'b0;
            r_change_valid <= 1'b1;
            r_state        <= IDLE;
            r_busy         <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_dispense_go <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign o_credit         = w_credit;
  assign o_change         = r_change;
  assign o_change_valid   = r_change_valid;
  assign o_sel_err        = r_sel_err;
  assign o_err_code       = r_err_code;
  assign o_dispense_go    = r_dispense_go;
  assign o_dispense_slot  = r_dispense_slot;
  assign o_busy           = r_busy;
  assign o_timeout_refund = r_timeout_refund;

endmodule

// File: tb/tb_vend_controller_multi.sv
// Directed testbench for vend_controller_multi.
// SLOT_W is widened to 5 so that an out-of-range slot (20) can be presented.
module tb_vend_controller_multi;

  localparam int NS = 16;
  localparam int SW = 5;
  localparam int CW = 10;
  localparam int KW = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             coin_valid;
  logic [KW-1:0]    coin_value;
  logic             return_all;
  logic             sel_valid;
  logic [SW-1:0]    sel_slot;
  logic [NS*CW-1:0] prices;
  logic [NS-1:0]    in_stock;
  logic             dispense_done;
  logic [CW-1:0]    credit;
  logic             coin_reject;
  logic [CW-1:0]    change;
  logic             change_valid;
  logic             sel_err;
  logic [1:0]       err_code;
  logic             dispense_go;
  logic [SW-1:0]    dispense_slot;
  logic             busy;
  logic             timeout_refund;

  int checks   = 0;
  int failures = 0;

  vend_controller_multi #(
    .NUM_SLOTS   (NS),
    .SLOT_W      (SW),
    .CREDIT_W    (CW),
    .MAX_CREDIT  (1000),
    .COIN_W      (KW),
    .TIMEOUT_CYC (16)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_coin_valid     (coin_valid),
    .i_coin_value     (coin_value),
    .i_return_all     (return_all),
    .i_sel_valid      (sel_valid),
    .i_sel_slot       (sel_slot),
    .i_prices         (prices),
    .i_in_stock       (in_stock),
    .i_dispense_done  (dispense_done),
    .o_credit         (credit),
    .o_coin_reject    (coin_reject),
    .o_change         (change),
    .o_change_valid   (change_valid),
    .o_sel_err        (sel_err),
    .o_err_code       (err_code),
    .o_dispense_go    (dispense_go),
    .o_dispense_slot  (dispense_slot),
    .o_busy           (busy),
    .o_timeout_refund (timeout_refund)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1;
    coin_value = KW'(v);
    tick();
    coin_valid = 1'b0;
    coin_value = '0;
  endtask

  task automatic select(input int s);
    sel_valid = 1'b1;
    sel_slot  = SW'(s);
    tick();
    sel_valid = 1'b0;
    sel_slot  = '0;
  endtask

  initial begin
    rst_n         = 1'b0;
    coin_valid    = 1'b0;
    coin_value    = '0;
    return_all    = 1'b0;
    sel_valid     = 1'b0;
    sel_slot      = '0;
    dispense_done = 1'b0;
    for (int i = 0; i < NS; i++) prices[i*CW +: CW] = 10'd100;
    prices[0*CW +: CW] = 10'd0;
    prices[3*CW +: CW] = 10'd200;
    prices[5*CW +: CW] = 10'd200;
    in_stock    = 16'hFFFF;
    in_stock[7] = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_credit", 32'(credit), 0);
    chk("rst_go", 32'(dispense_go), 0);
    chk("rst_cv", 32'(change_valid), 0);
    chk("rst_err", 32'(err_code), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tr", 32'(timeout_refund), 0);
    rst_n = 1'b1;
    tick();

    // Normal vend with change, coin bounced during VEND
    coin(100);
    chk("c1_credit", 32'(credit), 100);
    coin(100);
    coin(50);
    chk("c3_credit", 32'(credit), 250);
    chk("c3_rej", 32'(coin_reject), 0);
    select(3);
    chk("chk_busy", 32'(busy), 1);
    chk("chk_go", 32'(dispense_go), 0);
    tick();
    chk("vend_go", 32'(dispense_go), 1);
    chk("vend_slot", 32'(dispense_slot), 3);
    coin(50);
    chk("vend_coin_rej", 32'(coin_reject), 1);
    chk("vend_coin_credit", 32'(credit), 250);
    chk("vend_go_held", 32'(dispense_go), 1);
    dispense_done = 1'b1;
    tick();
    dispense_done = 1'b0;
    chk("done_go", 32'(dispense_go), 0);
    chk("done_cv", 32'(change_valid), 1);
    chk("done_change", 32'(change), 50);
    chk("done_credit", 32'(credit), 0);
    chk("done_busy", 32'(busy), 0);
    tick();
    chk("done_cv_pulse", 32'(change_valid), 0);

    // Credit ceiling
    for (int i = 0; i < 9; i++) coin(100);
    coin(90);
    chk("cap_990", 32'(credit), 990);
    coin(20);
    chk("cap_rej", 32'(coin_reject), 1);
    chk("cap_keep", 32'(credit), 990);
    coin(10);
    chk("cap_1000", 32'(credit), 1000);
    chk("cap_acc", 32'(coin_reject), 0);
    coin(0);
    chk("zero_coin", 32'(credit), 1000);
    chk("zero_coin_rej", 32'(coin_reject), 0);
    return_all = 1'b1;
    tick();
    return_all = 1'b0;
    chk("ref1000_cv", 32'(change_valid), 1);
    chk("ref1000_chg", 32'(change), 1000);
    chk("ref1000_credit", 32'(credit), 0);

    // Selection errors
    coin(100);
    coin(50);
    select(5);
    tick();
    chk("funds_err", 32'(sel_err), 1);
    chk("funds_code", 32'(err_code), 3);
    chk("funds_credit", 32'(credit), 150);
    chk("funds_go", 32'(dispense_go), 0);
    tick();
    chk("funds_pulse", 32'(sel_err), 0);
    chk("funds_hold", 32'(err_code), 3);
    select(20);
    tick();
    chk("slot_err", 32'(sel_err), 1);
    chk("slot_code", 32'(err_code), 1);
    select(7);
    tick();
    chk("sold_err", 32'(sel_err), 1);
    chk("sold_code", 32'(err_code), 2);
    chk("sold_credit", 32'(credit), 150);

    // Refund together with a coin
    coin(100);
    coin(50);
    chk("pre_ref", 32'(credit), 300);
    return_all = 1'b1;
    coin(25);
    return_all = 1'b0;
    chk("ref_cv", 32'(change_valid), 1);
    chk("ref_chg", 32'(change), 300);
    chk("ref_rej", 32'(coin_reject), 1);
    chk("ref_credit", 32'(credit), 0);
    return_all = 1'b1;
    tick();
    return_all = 1'b0;
    chk("ref_zero_ignored", 32'(change_valid), 0);

    // Reset during VEND
    coin(100);
    coin(100);
    select(3);
    tick();
    chk("rv_go", 32'(dispense_go), 1);
    rst_n = 1'b0;
    #1;
    chk("rv_go_rst", 32'(dispense_go), 0);
    chk("rv_credit_rst", 32'(credit), 0);
    chk("rv_busy_rst", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Free slot with dispense_done already high: 3-cycle transaction
    dispense_done = 1'b1;
    select(0);
    tick();
    chk("free_go", 32'(dispense_go), 1);
    chk("free_slot", 32'(dispense_slot), 0);
    tick();
    dispense_done = 1'b0;
    chk("free_done_go", 32'(dispense_go), 0);
    chk("free_cv", 32'(change_valid), 1);
    chk("free_chg", 32'(change), 0);

    // Idle timeout behaviour
    coin(70);
    for (int i = 0; i < 15; i++) tick();
    chk("to_before_tr", 32'(timeout_refund), 0);
    chk("to_before_credit", 32'(credit), 70);
    tick();
`ifdef VEND_TIMEOUT_EN
    chk("to_tr", 32'(timeout_refund), 1);
    chk("to_cv", 32'(change_valid), 1);
    chk("to_chg", 32'(change), 70);
    chk("to_credit", 32'(credit), 0);
`else
    chk("to_tr_off", 32'(timeout_refund), 0);
    chk("to_credit_kept", 32'(credit), 70);
    for (int i = 0; i < 8; i++) tick();
    chk("to_credit_kept2", 32'(credit), 70);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
